// File: rtl/priority_decoder8_seq_if.sv
// priority_decoder8_seq_if: index stream in, one-hot pulse and status out
interface priority_decoder8_seq_if #(parameter int DEPTH = 4) ();
  logic [2:0] in_idx;
  logic in_valid;
  logic in_ready;
  logic [7:0] out;
  logic out_valid;
  logic busy;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport slave (input in_idx, in_valid, output in_ready, out, out_valid, busy, count);
  modport master (output in_idx, in_valid, input in_ready, out, out_valid, busy, count);
endinterface

// File: rtl/priority_decoder8_seq.sv
// priority_decoder8_seq: FIFO-buffered 3-bit indices expanded to one-hot pulses of PULSE_CYCLES cycles
module priority_decoder8_seq #(
  parameter int DEPTH = 4,
  parameter int PULSE_CYCLES = 1
) (
  input logic clk,
  input logic rst_n,
  priority_decoder8_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, PULSE} state_e;
  state_e state_q, state_d;
  logic [2:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0] out_q, out_d;
  logic [3:0] hold_q, hold_d;
  logic push, pop;
  assign bus.in_ready = rst_n && count_q != CW'(DEPTH);
  assign push = bus.in_valid && bus.in_ready;
  always_comb begin
    pop = (state_q == IDLE || hold_q == 4'd0) && count_q != '0;
    state_d = (pop || (state_q == PULSE && hold_q != 4'd0)) ? PULSE : IDLE;
    out_d = pop ? 8'd1 << mem_q[rd_q] : (state_d == PULSE ? out_q : 8'd0);
    hold_d = pop ? 4'(PULSE_CYCLES - 1) : (hold_q != 4'd0 ? hold_q - 4'd1 : 4'd0);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      out_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      count_q <= count_d;
      out_q <= out_d;
      hold_q <= hold_d;
    end
  end
  // Storage needs no reset: occupancy and pointers alone decide what is readable
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.in_idx;
  end
  assign bus.out = out_q;
  assign bus.out_valid = state_q == PULSE;
  assign bus.busy = state_q == PULSE || count_q != '0;
  assign bus.count = count_q;
endmodule

// File: tb/tb_priority_decoder8_seq.sv
// tb_priority_decoder8_seq: two instances (pulse width 1 and 4) checked each cycle against a queue model
module tb_priority_decoder8_seq;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [2:0] in_idx = 0;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  logic [2:0] bp_in [6] = '{3'd7, 3'd3, 3'd3, 3'd1, 3'd6, 3'd2};
  logic [7:0] bp_exp [5] = '{8'h80, 8'h08, 8'h08, 8'h02, 8'h40};
  always #5 clk = ~clk;
  priority_decoder8_seq_if #(.DEPTH(4)) b1();
  priority_decoder8_seq_if #(.DEPTH(4)) b4();
  assign b1.in_idx = in_idx;
  assign b1.in_valid = in_valid;
  assign b4.in_idx = in_idx;
  assign b4.in_valid = in_valid;
  priority_decoder8_seq #(.DEPTH(4), .PULSE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  priority_decoder8_seq #(.DEPTH(4), .PULSE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  // Model: a queue of waiting indices plus the index on display and how many visible cycles remain
  for (genvar g = 0; g < 2; g++) begin : m
    localparam int P = g ? 4 : 1;
    logic [2:0] q [$];
    int rem = 0, sz = 0;
    logic [2:0] cur = 0;
    bit pushed;
    logic [7:0] e_out;
    logic e_valid, e_busy, e_ready;
    assign e_out = rem > 0 ? 8'd1 << cur : 8'd0;
    assign e_valid = rem > 0;
    assign e_busy = rem > 0 || sz > 0;
    assign e_ready = rst_n && sz < 4;
    always @(posedge clk) begin
      if (!rst_n) begin
        q.delete();
        rem = 0;
      end else begin
        pushed = in_valid && q.size() < 4;
        if (rem > 1) rem--;
        else if (q.size() > 0) begin
          cur = q.pop_front();
          rem = P;
        end else rem = 0;
        if (pushed) q.push_back(in_idx);
      end
      sz = q.size();
    end
  end
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d1_out", b1.out, m[0].e_out);
      chk("d1_valid", b1.out_valid, m[0].e_valid);
      chk("d1_busy", b1.busy, m[0].e_busy);
      chk("d1_ready", b1.in_ready, m[0].e_ready);
      chk("d1_count", b1.count, m[0].sz);
      chk("d4_out", b4.out, m[1].e_out);
      chk("d4_valid", b4.out_valid, m[1].e_valid);
      chk("d4_busy", b4.busy, m[1].e_busy);
      chk("d4_ready", b4.in_ready, m[1].e_ready);
      chk("d4_count", b4.count, m[1].sz);
    end
  end
  task automatic step(input bit v, input logic [2:0] i);
    in_valid = v;
    in_idx = i;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0);
  endtask
  initial begin
    int hb, pv, ph, dens;
    step(0, 0);
    step(0, 0);
    chk_en = 1;
    chk("rst_out", b1.out, 0);
    chk("rst_count", b4.count, 0);
    chk("rst_ready", b1.in_ready, 0);
    chk("rst_busy", b4.busy, 0);
    rst_n = 1;
    step(1, 5);
    step(0, 0);
    chk("single_out", b1.out, 8'h20);
    chk("single_valid", b1.out_valid, 1);
    step(0, 0);
    chk("single_idle", b1.out, 0);
    chk("single_busy", b1.busy, 0);
    idle(10);
    for (int i = 0; i < 8; i++) begin
      step(1, 3'(i));
      chk("sweep_ready", b1.in_ready, 1);
      if (i > 0) chk("sweep_out", b1.out, 1 << (i - 1));
    end
    step(0, 0);
    chk("sweep_out", b1.out, 8'h80);
    idle(40);
    step(1, bp_in[0]);
    for (int k = 0; k < 22; k++) begin
      if (k < 5) step(1, bp_in[k+1]);
      else step(0, 0);
      chk("bp_out", b4.out, k < 20 ? int'(bp_exp[k/4]) : 0);
      if (k == 3) begin
        chk("bp_count", b4.count, 4);
        chk("bp_ready", b4.in_ready, 0);
      end
    end
    idle(5);
    for (int s = 0; s < 15; s++) begin
      if (s == 0) step(1, 0);
      else if (s == 1) step(1, 6);
      else if (s == 5) step(1, 4);
      else step(0, 0);
      chk("sim_out", b4.out, s < 1 ? 0 : s < 5 ? 8'h01 : s < 9 ? 8'h40 : s < 13 ? 8'h10 : 0);
      if (s == 4 || s == 5) chk("sim_count", b4.count, 1);
    end
    idle(5);
    step(1, 2);
    step(1, 5);
    step(1, 6);
    step(1, 7);
    chk("mid_out", b4.out, 8'h04);
    chk("mid_count", b4.count, 3);
    rst_n = 0;
    step(0, 0);
    chk("mid_rst_out", b4.out, 0);
    chk("mid_rst_count", b4.count, 0);
    chk("mid_rst_ready", b4.in_ready, 0);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0);
      chk("mid_stale", b4.out | b1.out, 0);
    end
    pv = 0;
    ph = 0;
    for (int v = 1; v <= 255; v++) begin
      hb = $clog2(v + 1) - 1;
      step(1, 3'(hb));
      if (v > 1) begin
        chk("pair_out", b1.out, 1 << ph);
        chk("pair_msb", int'(b1.out <= 8'(pv) && 9'(b1.out) * 2 > 9'(pv)), 1);
      end
      pv = v;
      ph = hb;
    end
    step(0, 0);
    chk("pair_out", b1.out, 8'h80);
    idle(30);
    dens = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) dens = $urandom_range(10, 100);
      rst_n = $urandom_range(0, 199) != 0;
      step($urandom_range(0, 99) < dens, 3'($urandom_range(0, 7)));
    end
    rst_n = 1;
    idle(30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
